// File: rtl/alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// alu_cmd_sequencer
//   Command-side controller for a 4-bit combinational ALU. A command is taken
//   over a valid/ready handshake, its operands are registered, the ALU is
//   evaluated from those registers, and the result is returned over a
//   valid/ready response channel. An accumulator holds the last result so
//   commands can chain on it; op_cnt counts completed responses.
//
//   Optional feature macro: ALU_ERR_EN adds the rsp_err divide-by-zero flag.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   cmd_valid/cmd_ready command handshake
//   cmd_oc, cmd_a/b     opcode and operands (ADD,SUB,MUL,DIV,NOT,XOR,OR,AND)
//   cmd_use_acc         take operand A from the accumulator
//   acc_clr             reload ACC_INIT into the accumulator (IDLE only)
//   rsp_valid/rsp_ready response handshake, rsp_f result
//   acc                 accumulator value
//   op_cnt              completed-response count (wraps)
//   rsp_err             divide-by-zero flag (ALU_ERR_EN only)
// ---------------------------------------------------------------------------

// Combinational 4-bit ALU; arithmetic wraps modulo 16.
module alu (
    input  logic [2:0] oc_i,
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [3:0] f_o
);
    always_comb begin
        f_o = 4'h0;
        case (oc_i)
            3'd0: f_o = a_i + b_i;
            3'd1: f_o = a_i - b_i;
            3'd2: f_o = a_i * b_i;
            3'd3: f_o = a_i / b_i;
            3'd4: f_o = ~a_i;
            3'd5: f_o = a_i ^ b_i;
            3'd6: f_o = a_i | b_i;
            default: f_o = a_i & b_i;
        endcase
    end
endmodule

module alu_cmd_sequencer #(
    parameter int unsigned CNT_W    = 8,
    parameter logic [3:0]  ACC_INIT = 4'h0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_oc,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,
    input  logic             cmd_use_acc,
    input  logic             acc_clr,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [3:0]       rsp_f,
    output logic [3:0]       acc,
    output logic [CNT_W-1:0] op_cnt
`ifdef ALU_ERR_EN
    ,
    output logic             rsp_err
`endif
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] OC_DIV = 3'd3;

    state_t           state_q;
    logic             cmd_ready_q;
    logic             rsp_valid_q;
    logic [3:0]       rsp_f_q;
    logic [3:0]       acc_q;
    logic [CNT_W-1:0] op_cnt_q;
    logic [2:0]       oc_q;
    logic [3:0]       op_a_q;
    logic [3:0]       op_b_q;
`ifdef ALU_ERR_EN
    logic             rsp_err_q;
`endif

    logic [3:0] alu_f;
    logic       div0;
    logic [3:0] res_d;
    logic [3:0] op_a_d;

    // The ALU only ever sees the registered operands.
    alu u_alu (
        .oc_i (oc_q),
        .a_i  (op_a_q),
        .b_i  (op_b_q),
        .f_o  (alu_f)
    );

    // Divide by zero returns all ones whatever the ALU produces.
    assign div0  = (oc_q == OC_DIV) && (op_b_q == 4'h0);
    assign res_d = div0 ? 4'hF : alu_f;

    // A clear in the accept cycle beats the accumulator for operand A too.
    assign op_a_d = !cmd_use_acc ? cmd_a :
                    acc_clr      ? ACC_INIT : acc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_f_q     <= 4'h0;
            acc_q       <= ACC_INIT;
            op_cnt_q    <= '0;
            oc_q        <= 3'd0;
            op_a_q      <= 4'h0;
            op_b_q      <= 4'h0;
`ifdef ALU_ERR_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (acc_clr) acc_q <= ACC_INIT;
                    if (cmd_valid) begin
                        oc_q        <= cmd_oc;
                        op_a_q      <= op_a_d;
                        op_b_q      <= cmd_b;
                        cmd_ready_q <= 1'b0;
                        state_q     <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_f_q     <= res_d;
                    acc_q       <= res_d;
                    rsp_valid_q <= 1'b1;
`ifdef ALU_ERR_EN
                    rsp_err_q   <= div0;
`endif
                    state_q     <= RESP;
                end
                RESP: begin
                    // No bypass: the next command is only seen back in IDLE.
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        op_cnt_q    <= op_cnt_q + CNT_W'(1);
                        cmd_ready_q <= 1'b1;
`ifdef ALU_ERR_EN
                        rsp_err_q   <= 1'b0;
`endif
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    cmd_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_f     = rsp_f_q;
    assign acc       = acc_q;
    assign op_cnt    = op_cnt_q;
`ifdef ALU_ERR_EN
    assign rsp_err   = rsp_err_q;
`endif

endmodule
